// File: rtl/exec_pkg.sv
// Shared definitions for the multi-cycle execute stage: ALU op codes,
// forward-select codes and the multiply sequencing FSM states.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_MUL = 4'b1000
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_W      = 2'b01,
        FWD_M      = 2'b10,
        FWD_RF_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/execute_stage_mc_if.sv
// E-stage inputs and M-stage register outputs of the execute stage.
// slave = the execute stage, master = the surrounding pipeline.
interface execute_stage_mc_if #(
    parameter int DATA_W = 24,
    parameter int REG_AW = 5
);
    logic              ValidE;
    logic              RegWriteE;
    logic              ALUSrcE;
    logic              MemWriteE;
    logic              ResultSrcE;
    logic              BranchE;
    logic [3:0]        ALUControlE;
    logic [DATA_W-1:0] RD1_E;
    logic [DATA_W-1:0] RD2_E;
    logic [DATA_W-1:0] Imm_Ext_E;
    logic [DATA_W-1:0] PCE;
    logic [DATA_W-1:0] PCPlus4E;
    logic [DATA_W-1:0] ResultW;
    logic [REG_AW-1:0] RD_E;
    logic [1:0]        ForwardA_E;
    logic [1:0]        ForwardB_E;
    logic              FlushE;

    logic              StallE;
    logic              PCSrcE;
    logic [DATA_W-1:0] PCTargetE;

    logic              RegWriteM;
    logic              MemWriteM;
    logic              ResultSrcM;
    logic              ValidM;
    logic [REG_AW-1:0] RD_M;
    logic [DATA_W-1:0] PCPlus4M;
    logic [DATA_W-1:0] WriteDataM;
    logic [DATA_W-1:0] ALU_ResultM;

    modport master (
        output ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW,
               RD_E, ForwardA_E, ForwardB_E, FlushE,
        input  StallE, PCSrcE, PCTargetE,
               RegWriteM, MemWriteM, ResultSrcM, ValidM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport slave (
        input  ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW,
               RD_E, ForwardA_E, ForwardB_E, FlushE,
        output StallE, PCSrcE, PCTargetE,
               RegWriteM, MemWriteM, ResultSrcM, ValidM, RD_M,
               PCPlus4M, WriteDataM, ALU_ResultM
    );

endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle,
// DATA_W iterations, low DATA_W bits of the unsigned product.
module mul_seq #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CW-1:0]     cnt;
    logic              run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (abort) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST)
                run <= 1'b0;
        end
    end

    // done marks the cycle whose edge completes the final iteration
    assign busy    = run;
    assign done    = run && (cnt == LAST);
    assign product = acc;

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage with forwarding, single-cycle ALU, branch resolution and a
// multi-cycle multiply that stalls upstream while mul_seq iterates.
module execute_stage_mc
    import exec_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int REG_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    execute_stage_mc_if.slave bus
);

    localparam logic [DATA_W-1:0] W_MOD = DATA_W'(DATA_W);

    state_e            state, state_nx;
    logic [DATA_W-1:0] fwd_a, fwd_b, src_a, src_b;
    logic [DATA_W-1:0] alu_res, shamt;
    logic              zero, issue, stall;
    logic              load_alu, load_mul;

    logic              lat_regwrite, lat_memwrite, lat_resultsrc;
    logic [REG_AW-1:0] lat_rd;
    logic [DATA_W-1:0] lat_pcplus4, lat_wdata;

    logic              mul_busy, mul_done;
    logic [DATA_W-1:0] mul_product;

    always_comb begin
        case (fwd_sel_e'(bus.ForwardA_E))
            FWD_W:   fwd_a = bus.ResultW;
            FWD_M:   fwd_a = bus.ALU_ResultM;
            default: fwd_a = bus.RD1_E;
        endcase
        case (fwd_sel_e'(bus.ForwardB_E))
            FWD_W:   fwd_b = bus.ResultW;
            FWD_M:   fwd_b = bus.ALU_ResultM;
            default: fwd_b = bus.RD2_E;
        endcase
    end

    assign src_a = fwd_a;
    assign src_b = bus.ALUSrcE ? bus.Imm_Ext_E : fwd_b;
    assign shamt = src_b % W_MOD;

    // MUL yields no single-cycle result; its product arrives from mul_seq
    always_comb begin
        alu_res = '0;
        case (alu_op_e'(bus.ALUControlE))
            ALU_ADD: alu_res = src_a + src_b;
            ALU_SUB: alu_res = src_a - src_b;
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_XOR: alu_res = src_a ^ src_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLL: alu_res = src_a << shamt;
            ALU_SRL: alu_res = src_a >> shamt;
            default: alu_res = '0;
        endcase
    end

    assign zero  = (alu_res == '0);
    assign issue = (state == IDLE) && bus.ValidE && !bus.FlushE
                   && (alu_op_e'(bus.ALUControlE) == ALU_MUL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                stall = issue;
                if (issue)
                    state_nx = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.FlushE || !mul_busy)
                    state_nx = IDLE;
                else if (mul_done)
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!rst)
            stall = 1'b0;
    end

    assign bus.StallE    = stall;
    assign bus.PCSrcE    = bus.BranchE & zero & bus.ValidE & ~bus.FlushE & ~stall;
    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;

    mul_seq #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (issue),
        .abort   (bus.FlushE),
        .a       (src_a),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_regwrite  <= 1'b0;
            lat_memwrite  <= 1'b0;
            lat_resultsrc <= 1'b0;
            lat_rd        <= '0;
            lat_pcplus4   <= '0;
            lat_wdata     <= '0;
        end else if (issue) begin
            lat_regwrite  <= bus.RegWriteE;
            lat_memwrite  <= bus.MemWriteE;
            lat_resultsrc <= bus.ResultSrcE;
            lat_rd        <= bus.RD_E;
            lat_pcplus4   <= bus.PCPlus4E;
            lat_wdata     <= fwd_b;
        end
    end

    assign load_alu = (state == IDLE) && bus.ValidE && !bus.FlushE && !issue;
    assign load_mul = (state == DONE) && !bus.FlushE;

    // Anything not loaded is a bubble: valid/write strobes drop, data holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.RegWriteM   <= 1'b0;
            bus.MemWriteM   <= 1'b0;
            bus.ResultSrcM  <= 1'b0;
            bus.ValidM      <= 1'b0;
            bus.RD_M        <= '0;
            bus.PCPlus4M    <= '0;
            bus.WriteDataM  <= '0;
            bus.ALU_ResultM <= '0;
        end else if (load_alu) begin
            bus.RegWriteM   <= bus.RegWriteE;
            bus.MemWriteM   <= bus.MemWriteE;
            bus.ResultSrcM  <= bus.ResultSrcE;
            bus.ValidM      <= 1'b1;
            bus.RD_M        <= bus.RD_E;
            bus.PCPlus4M    <= bus.PCPlus4E;
            bus.WriteDataM  <= fwd_b;
            bus.ALU_ResultM <= alu_res;
        end else if (load_mul) begin
            bus.RegWriteM   <= lat_regwrite;
            bus.MemWriteM   <= lat_memwrite;
            bus.ResultSrcM  <= lat_resultsrc;
            bus.ValidM      <= 1'b1;
            bus.RD_M        <= lat_rd;
            bus.PCPlus4M    <= lat_pcplus4;
            bus.WriteDataM  <= lat_wdata;
            bus.ALU_ResultM <= mul_product;
        end else begin
            bus.RegWriteM   <= 1'b0;
            bus.MemWriteM   <= 1'b0;
            bus.ValidM      <= 1'b0;
        end
    end

endmodule
